// File: rtl/fifo_wr_skid.sv
// fifo_wr_skid: write-side ingress stage for the async FIFO with a 2-entry skid buffer and debug counters
// Ports:
//    wclk, wrst_n          write clock, asynchronous active-low reset
//    in_data/in_valid      upstream stream in
//    in_ready              upstream accept, depends only on registered occupancy
//    wfull                 FIFO full flag, may change asynchronously
//    winc/wdata            FIFO write port
//    clr_cnt               synchronous clear of wr_cnt and stall_cnt
//    wr_cnt                words written (wrapping), stall_cnt pending-while-full cycles (saturating)
//    occ                   buffer occupancy 0..2
module fifo_wr_skid #(
   parameter int DATASIZE = 8,
   parameter int CNTSIZE  = 16
) (
   input  logic                wclk,
   input  logic                wrst_n,
   input  logic [DATASIZE-1:0] in_data,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                wfull,
   output logic                winc,
   output logic [DATASIZE-1:0] wdata,
   input  logic                clr_cnt,
   output logic [CNTSIZE-1:0]  wr_cnt,
   output logic [CNTSIZE-1:0]  stall_cnt,
   output logic [1:0]          occ
);
   logic [DATASIZE-1:0] head, skid;
   logic                push, pop;
   assign wdata    = head;
   // combinational on wfull so a late full assertion withdraws the write before the edge
   assign winc     = (occ != 2'd0) & ~wfull;
   assign in_ready = (occ != 2'd2);
   assign push     = in_valid & in_ready;
   assign pop      = winc;
   // push and pop together only happens at occ == 1, since in_ready is low at occ == 2
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         occ       <= '0;
         head      <= '0;
         skid      <= '0;
         wr_cnt    <= '0;
         stall_cnt <= '0;
      end else begin
         head      <= (push && (occ == 2'd0 || pop)) ? in_data : pop ? skid : head;
         skid      <= (push && !pop && occ == 2'd1) ? in_data : skid;
         occ       <= occ + {1'b0, push} - {1'b0, pop};
         wr_cnt    <= clr_cnt ? '0 : wr_cnt + {{(CNTSIZE-1){1'b0}}, pop};
         stall_cnt <= clr_cnt ? '0 :
                      (occ != 2'd0 && wfull && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
      end
   end
endmodule

// File: tb/tb_fifo_wr_skid.sv
// tb_fifo_wr_skid: self-checking bench for fifo_wr_skid against a queue-based reference model
module tb_fifo_wr_skid;
   logic        wclk = 1'b0, wrst_n = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0, wfull = 1'b0, clr_cnt = 1'b0;
   logic        in_ready, winc;
   logic [7:0]  wdata;
   logic [15:0] wr_cnt, stall_cnt;
   logic [1:0]  occ;
   logic        in_ready4, winc4;
   logic [7:0]  wdata4;
   logic [3:0]  wr_cnt4, stall_cnt4;
   logic [1:0]  occ4;

   always #5 wclk = ~wclk;

   fifo_wr_skid #(.DATASIZE(8), .CNTSIZE(16)) dut (
      .wclk(wclk), .wrst_n(wrst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .wfull(wfull), .winc(winc), .wdata(wdata), .clr_cnt(clr_cnt), .wr_cnt(wr_cnt),
      .stall_cnt(stall_cnt), .occ(occ));

   fifo_wr_skid #(.DATASIZE(8), .CNTSIZE(4)) dut4 (
      .wclk(wclk), .wrst_n(wrst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
      .wfull(wfull), .winc(winc4), .wdata(wdata4), .clr_cnt(clr_cnt), .wr_cnt(wr_cnt4),
      .stall_cnt(stall_cnt4), .occ(occ4));

   int total = 0, bad = 0;
   logic [7:0] q[$];
   int wr_tot = 0, st_tot = 0, acc_tot = 0;
   logic       s_winc, s_rdy;
   logic [1:0] s_occ;
   logic [7:0] s_wdata;

   typedef struct {
      logic v; logic [7:0] d; logic f;
      logic [1:0] eo; logic ew; logic er; logic [7:0] ed; logic cd;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", n, a, e, $time);
      end
   endtask

   function automatic int sat(input int x, input int m);
      return (x > m) ? m : x;
   endfunction

   task automatic cyc(input logic v, input logic [7:0] d, input logic f, input logic c);
      int  n;
      logic psh, pp;
      @(negedge wclk);
      in_valid = v; in_data = d; wfull = f; clr_cnt = c;
      #1;
      n = q.size();
      s_winc = winc; s_rdy = in_ready; s_occ = occ; s_wdata = wdata;
      chk("occ", 32'(occ), 32'(n));
      chk("winc", 32'(winc), 32'(n != 0 && !f));
      chk("in_ready", 32'(in_ready), 32'(n != 2));
      if (n != 0) chk("wdata", 32'(wdata), 32'(q[0]));
      chk("wr_cnt", 32'(wr_cnt), 32'(wr_tot % 65536));
      chk("stall_cnt", 32'(stall_cnt), 32'(sat(st_tot, 65535)));
      chk("wr_cnt4", 32'(wr_cnt4), 32'(wr_tot % 16));
      chk("stall_cnt4", 32'(stall_cnt4), 32'(sat(st_tot, 15)));
      chk("winc_and_wfull", 32'(winc & wfull), 32'd0);
      psh = v && n < 2;
      pp  = n != 0 && !f;
      @(posedge wclk);
      if (pp) void'(q.pop_front());
      if (psh) q.push_back(d);
      acc_tot += int'(psh);
      if (c) begin wr_tot = 0; st_tot = 0; end
      else begin wr_tot += int'(pp); st_tot += int'(n != 0 && f); end
   endtask

   task automatic do_reset();
      in_valid = 0; wfull = 0; clr_cnt = 0; in_data = 0;
      @(posedge wclk);
      #3 wrst_n = 0;
      #1;
      chk("rst_occ", 32'(occ), 0);
      chk("rst_winc", 32'(winc), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_wdata", 32'(wdata), 0);
      chk("rst_wr_cnt", 32'(wr_cnt), 0);
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
      @(negedge wclk);
      wrst_n = 1;
      q.delete(); wr_tot = 0; st_tot = 0; acc_tot = 0;
   endtask

   initial begin
      int wincs, first, last, mx;
      logic [7:0] got[$];
      // backpressure table: outputs expected before each edge, starting from empty after reset
      tbl[0] = '{1, 8'hA0, 0, 2'd0, 0, 1, 8'h00, 1};
      tbl[1] = '{1, 8'hA1, 1, 2'd1, 0, 1, 8'hA0, 1};
      tbl[2] = '{1, 8'hA2, 1, 2'd2, 0, 0, 8'hA0, 1};
      tbl[3] = '{1, 8'hA2, 1, 2'd2, 0, 0, 8'hA0, 1};
      tbl[4] = '{1, 8'hA2, 1, 2'd2, 0, 0, 8'hA0, 1};
      tbl[5] = '{1, 8'hA2, 1, 2'd2, 0, 0, 8'hA0, 1};
      tbl[6] = '{1, 8'hA2, 0, 2'd2, 1, 0, 8'hA0, 1};
      tbl[7] = '{1, 8'hA2, 0, 2'd1, 1, 1, 8'hA1, 1};
      tbl[8] = '{0, 8'h00, 0, 2'd1, 1, 1, 8'hA2, 1};
      tbl[9] = '{0, 8'h00, 0, 2'd0, 0, 1, 8'h00, 0};

      #2;
      chk("init_occ", 32'(occ), 0);
      chk("init_in_ready", 32'(in_ready), 1);
      chk("init_wdata", 32'(wdata), 0);
      @(negedge wclk);
      wrst_n = 1;

      // streaming 0x01..0x10
      wincs = 0; first = -1; last = -1; mx = 0;
      for (int i = 0; i < 18; i++) begin
         cyc(i < 16, 8'(i + 1), 0, 0);
         if (32'(s_occ) > mx) mx = 32'(s_occ);
         if (s_winc) begin
            wincs++; got.push_back(s_wdata);
            if (first < 0) first = i;
            last = i;
         end
      end
      chk("stream_wincs", wincs, 16);
      chk("stream_first", first, 1);
      chk("stream_last", last, 16);
      chk("stream_max_occ", mx, 1);
      for (int i = 0; i < 16; i++) chk("stream_seq", 32'(got[i]), i + 1);
      #1 chk("stream_wr_cnt", 32'(wr_cnt), 16);

      // fill to occ 2, then reset mid-cycle
      cyc(1, 8'h11, 1, 0);
      cyc(1, 8'h22, 1, 0);
      #1 chk("fill_occ", 32'(occ), 2);
      do_reset();

      // backpressure table
      for (int i = 0; i < 10; i++) begin
         cyc(tbl[i].v, tbl[i].d, tbl[i].f, 0);
         chk("tbl_occ", 32'(s_occ), 32'(tbl[i].eo));
         chk("tbl_winc", 32'(s_winc), 32'(tbl[i].ew));
         chk("tbl_in_ready", 32'(s_rdy), 32'(tbl[i].er));
         if (tbl[i].cd) chk("tbl_wdata", 32'(s_wdata), 32'(tbl[i].ed));
      end
      #1;
      chk("bp_stall_cnt", 32'(stall_cnt), 5);
      chk("bp_wr_cnt", 32'(wr_cnt), 3);

      // asynchronous full between edges at occ 1
      cyc(1, 8'h55, 0, 0);
      @(negedge wclk);
      in_valid = 0; wfull = 0;
      #1 chk("async_winc_before", 32'(winc), 1);
      #2 wfull = 1;
      #1 chk("async_winc_dropped", 32'(winc), 0);
      @(posedge wclk);
      st_tot++;
      #1;
      chk("async_wr_cnt", 32'(wr_cnt), 32'(wr_tot));
      chk("async_occ", 32'(occ), 1);
      chk("async_head", 32'(wdata), 8'h55);

      // clear in the same cycle as a pop
      cyc(0, 0, 0, 1);
      #1;
      chk("clr_wr_cnt", 32'(wr_cnt), 0);
      chk("clr_stall_cnt", 32'(stall_cnt), 0);

      // stall saturation on the 4-bit instance
      cyc(1, 8'h77, 1, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0);
      #1;
      chk("sat_stall_cnt4", 32'(stall_cnt4), 15);
      chk("sat_stall_cnt", 32'(stall_cnt), 20);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);

      // random traffic
      do_reset();
      for (int i = 0; i < 10000; i++)
         cyc(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 3), 0);
      #1;
      chk("rand_wr_vs_acc", 32'(wr_cnt), 32'((acc_tot - int'(q.size())) % 65536));
      chk("rand_occ", 32'(occ), 32'(q.size()));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
